// File: rtl/int_arbiter.sv
// Fixed-priority 4-source interrupt arbiter with edge-latched pending bits and a request/ack/return handshake.
// Define INT_ARBITER_NEST_EN to let a higher-priority source preempt one already in service.
module int_arbiter #(
    parameter logic [7:0] VEC0 = 8'd19,
    parameter logic [7:0] VEC1 = 8'd34,
    parameter logic [7:0] VEC2 = 8'd49,
    parameter logic [7:0] VEC3 = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  irq_in,
    input  logic        cfg_we,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    output logic        int_req,
    input  logic        int_ack,
    output logic [7:0]  int_vec,
    output logic [1:0]  int_id,
    input  logic        int_ret,
    output logic [3:0]  in_service
);

    localparam int unsigned NSRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NSRC-1:0]   irq_d_q;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   en_q, en_d;
    logic              glob_en_q, glob_en_d;
    logic [NSRC-1:0]   in_service_q, in_service_d;
    logic              int_req_q, int_req_d;
    logic [1:0]        int_id_q, int_id_d;
    logic [7:0]        int_vec_q, int_vec_d;

    logic [NSRC-1:0]   edge_c;
    logic [NSRC-1:0]   cand_c;
    logic [NSRC-1:0]   isv_after_ret_c;
`ifdef INT_ARBITER_NEST_EN
    logic [NSRC-1:0]   above_mask_c;
`endif
    logic              unused_cfg_c;

    function automatic logic [1:0] lowest_idx(input logic [NSRC-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] vec_of(input logic [1:0] id);
        logic [7:0] r;
        case (id)
            2'd0:    r = VEC0;
            2'd1:    r = VEC1;
            2'd2:    r = VEC2;
            default: r = VEC3;
        endcase
        return r;
    endfunction

    assign edge_c          = irq_in & ~irq_d_q;
    assign cand_c          = pending_q & en_q & {NSRC{glob_en_q}};
    // Clearing the lowest set bit retires the most recently nested service.
    assign isv_after_ret_c = in_service_q & (in_service_q - 4'd1);
`ifdef INT_ARBITER_NEST_EN
    // Sources strictly above (lower index than) the lowest in-service bit.
    assign above_mask_c    = (in_service_q & (~in_service_q + 4'd1)) - 4'd1;
`endif
    assign unused_cfg_c    = ^{cfg_wdata[14:12], cfg_wdata[7:4]};

    // Next-state and handshake decode.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        en_d         = en_q;
        glob_en_d    = glob_en_q;
        in_service_d = in_service_q;
        int_id_d     = int_id_q;
        int_vec_d    = int_vec_q;

        if (cfg_we) begin
            glob_en_d = cfg_wdata[15];
            en_d      = cfg_wdata[11:8];
            pending_d = pending_d & ~cfg_wdata[3:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (|cand_c) begin
                    state_d   = ST_REQ;
                    int_id_d  = lowest_idx(cand_c);
                    int_vec_d = vec_of(lowest_idx(cand_c));
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    pending_d[int_id_q]    = 1'b0;
                    in_service_d[int_id_q] = 1'b1;
                    state_d                = ST_SERVICE;
                end else if (!cand_c[int_id_q]) begin
                    // Withdrawn request: resume any interrupted service.
                    state_d = (|in_service_q) ? ST_SERVICE : ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (int_ret && (|in_service_q)) begin
                    in_service_d = isv_after_ret_c;
                    if (isv_after_ret_c == '0) state_d = ST_IDLE;
                end
`ifdef INT_ARBITER_NEST_EN
                else if (|(cand_c & above_mask_c)) begin
                    state_d   = ST_REQ;
                    int_id_d  = lowest_idx(cand_c & above_mask_c);
                    int_vec_d = vec_of(lowest_idx(cand_c & above_mask_c));
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh edge always wins over W1C or ack clears in the same cycle.
        pending_d = pending_d | edge_c;
        int_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            irq_d_q      <= '0;
            pending_q    <= '0;
            en_q         <= '0;
            glob_en_q    <= 1'b0;
            in_service_q <= '0;
            int_req_q    <= 1'b0;
            int_id_q     <= 2'd0;
            int_vec_q    <= VEC0;
        end else begin
            state_q      <= state_d;
            irq_d_q      <= irq_in;
            pending_q    <= pending_d;
            en_q         <= en_d;
            glob_en_q    <= glob_en_d;
            in_service_q <= in_service_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
            int_vec_q    <= int_vec_d;
        end
    end

    assign cfg_rdata  = {glob_en_q, 3'b000, en_q, in_service_q, pending_q};
    assign int_req    = int_req_q;
    assign int_id     = int_id_q;
    assign int_vec    = int_vec_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed vector bench for int_arbiter; expectations follow INT_ARBITER_NEST_EN when defined.
module tb_int_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_in;
    logic        cfg_we;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        int_req;
    logic        int_ack;
    logic [7:0]  int_vec;
    logic [1:0]  int_id;
    logic        int_ret;
    logic [3:0]  in_service;

    int checks   = 0;
    int failures = 0;

    int_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .cfg_we     (cfg_we),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .int_req    (int_req),
        .int_ack    (int_ack),
        .int_vec    (int_vec),
        .int_id     (int_id),
        .int_ret    (int_ret),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] wd;
        logic [3:0]  irq;
        logic        ack;
        logic        ret;
        logic        e_req;
        logic [1:0]  e_id;
        logic [7:0]  e_vec;
        logic [3:0]  e_isv;
        logic [15:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic [15:0] wd, input logic [3:0] irq,
                                input logic ack, input logic ret, input logic e_req,
                                input logic [1:0] e_id, input logic [7:0] e_vec,
                                input logic [3:0] e_isv, input logic [15:0] e_rd);
        vec_t v;
        v.we = we; v.wd = wd; v.irq = irq; v.ack = ack; v.ret = ret;
        v.e_req = e_req; v.e_id = e_id; v.e_vec = e_vec; v.e_isv = e_isv; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input int step, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", nm, step, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int step, input logic e_req, input logic [1:0] e_id,
                              input logic [7:0] e_vec, input logic [3:0] e_isv, input logic [15:0] e_rd);
        chk({tag, "_req"}, step, 16'(int_req), 16'(e_req));
        chk({tag, "_id"},  step, 16'(int_id), 16'(e_id));
        chk({tag, "_vec"}, step, 16'(int_vec), 16'(e_vec));
        chk({tag, "_isv"}, step, 16'(in_service), 16'(e_isv));
        chk({tag, "_rd"},  step, cfg_rdata, e_rd);
    endtask

    task automatic drive(input logic we, input logic [15:0] wd, input logic [3:0] irq,
                         input logic ack, input logic ret);
        cfg_we = we; cfg_wdata = wd; irq_in = irq; int_ack = ack; int_ret = ret;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);

        //          we  wdata     irq ack ret  req id vec   isv  rdata
        tbl.push_back(mk(1, 16'h8100, 4'h0, 0, 0, 0, 0, 8'd19, 4'h0, 16'h8100));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 0, 0, 0, 0, 8'd19, 4'h0, 16'h8100));
        tbl.push_back(mk(0, 16'h0000, 4'h1, 0, 0, 0, 0, 8'd19, 4'h0, 16'h8101));
        tbl.push_back(mk(0, 16'h0000, 4'h1, 0, 0, 1, 0, 8'd19, 4'h0, 16'h8101));
        tbl.push_back(mk(0, 16'h0000, 4'h1, 1, 0, 0, 0, 8'd19, 4'h1, 16'h8110));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 0, 1, 0, 0, 8'd19, 4'h0, 16'h8100));
        tbl.push_back(mk(1, 16'h8300, 4'h0, 0, 0, 0, 0, 8'd19, 4'h0, 16'h8300));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 0, 0, 8'd19, 4'h0, 16'h8303));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 1, 0, 8'd19, 4'h0, 16'h8303));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 1, 0, 0, 0, 8'd19, 4'h1, 16'h8312));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 0, 0, 8'd19, 4'h1, 16'h8312));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 1, 0, 0, 8'd19, 4'h0, 16'h8302));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 1, 1, 8'd34, 4'h0, 16'h8302));
        // W1C of the requested source withdraws the request.
        tbl.push_back(mk(1, 16'h8202, 4'h3, 0, 0, 1, 1, 8'd34, 4'h0, 16'h8200));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 0, 1, 8'd34, 4'h0, 16'h8200));
        // Stray ack and stray return are ignored.
        tbl.push_back(mk(0, 16'h0000, 4'h3, 1, 0, 0, 1, 8'd34, 4'h0, 16'h8200));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 1, 0, 1, 8'd34, 4'h0, 16'h8200));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 0, 0, 0, 1, 8'd34, 4'h0, 16'h8200));
        // Edge and W1C on the same bit: set wins.
        tbl.push_back(mk(1, 16'h8202, 4'h2, 0, 0, 0, 1, 8'd34, 4'h0, 16'h8202));
        tbl.push_back(mk(0, 16'h0000, 4'h2, 0, 0, 1, 1, 8'd34, 4'h0, 16'h8202));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 0, 0, 1, 1, 8'd34, 4'h0, 16'h8202));
        // Edge and ack on the same source: pending stays set.
        tbl.push_back(mk(0, 16'h0000, 4'h2, 1, 0, 0, 1, 8'd34, 4'h2, 16'h8222));
        tbl.push_back(mk(0, 16'h0000, 4'h2, 0, 1, 0, 1, 8'd34, 4'h0, 16'h8202));
        tbl.push_back(mk(0, 16'h0000, 4'h2, 0, 0, 1, 1, 8'd34, 4'h0, 16'h8202));
        tbl.push_back(mk(0, 16'h0000, 4'h2, 1, 0, 0, 1, 8'd34, 4'h2, 16'h8220));
        // Source 1 in service; source 0 rises.
        tbl.push_back(mk(1, 16'h8300, 4'h2, 0, 0, 0, 1, 8'd34, 4'h2, 16'h8320));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 0, 1, 8'd34, 4'h2, 16'h8321));
`ifdef INT_ARBITER_NEST_EN
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 1, 0, 8'd19, 4'h2, 16'h8321));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 1, 0, 0, 0, 8'd19, 4'h3, 16'h8330));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 1, 0, 0, 8'd19, 4'h2, 16'h8320));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 1, 0, 0, 8'd19, 4'h0, 16'h8300));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 0, 0, 8'd19, 4'h0, 16'h8300));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 0, 0, 8'd19, 4'h0, 16'h8300));
`else
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 0, 1, 8'd34, 4'h2, 16'h8321));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 0, 1, 8'd34, 4'h2, 16'h8321));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 1, 0, 1, 8'd34, 4'h0, 16'h8301));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 0, 1, 0, 8'd19, 4'h0, 16'h8301));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 1, 0, 0, 0, 8'd19, 4'h1, 16'h8310));
        tbl.push_back(mk(0, 16'h0000, 4'h3, 0, 1, 0, 0, 8'd19, 4'h0, 16'h8300));
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 0, 1'b0, 2'd0, 8'd19, 4'h0, 16'h0000);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].wd, tbl[i].irq, tbl[i].ack, tbl[i].ret);
            @(posedge clk);
            #1;
            check_outs("vec", i + 1, tbl[i].e_req, tbl[i].e_id, tbl[i].e_vec, tbl[i].e_isv, tbl[i].e_rd);
            @(negedge clk);
        end

        // Enter SERVICE for source 0, then pulse reset.
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h0, 4'h1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", 0, 16'(int_req), 16'h1);
        drive(1'b0, 16'h0, 4'h1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h0, 4'h1, 1'b0, 1'b0);
        chk("pre_rst_isv", 0, 16'(in_service), 16'h1);
        rst = 1'b1;
        #1;
        check_outs("rst_async", 0, 1'b0, 2'd0, 8'd19, 4'h0, 16'h0000);
        @(posedge clk);
        #1;
        check_outs("rst_held", 0, 1'b0, 2'd0, 8'd19, 4'h0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);

        // Latency: rise sampled at edge N, request visible after edge N+1.
        drive(1'b1, 16'h8100, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h0, 4'h1, 1'b0, 1'b0);
        n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            n = k;
            if (int_req) break;
        end
        chk("latency", 0, 16'(n), 16'd2);
        chk("lat_vec", 0, 16'(int_vec), 16'd19);
        chk("lat_id",  0, 16'(int_id), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
